// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, type field geometry, controller state encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package noc_pkg;

   // Flit type lives in the top TYPE_W bits of every flit.
   localparam int TYPE_W = 2;

   localparam logic [TYPE_W-1:0] FLIT_BODY   = 2'b00;
   localparam logic [TYPE_W-1:0] FLIT_HEAD   = 2'b01;
   localparam logic [TYPE_W-1:0] FLIT_TAIL   = 2'b10;
   localparam logic [TYPE_W-1:0] FLIT_SINGLE = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } ipcState_t;

   // Head and single both open a packet.
   function automatic logic opensPacket(input logic [TYPE_W-1:0] flitType);
      return (flitType == FLIT_HEAD) || (flitType == FLIT_SINGLE);
   endfunction

   // Tail and single both close a packet.
   function automatic logic closesPacket(input logic [TYPE_W-1:0] flitType);
      return (flitType == FLIT_TAIL) || (flitType == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with wrap-around pointers and occupancy counter.
// Latency: a flit written at edge t is visible on front after t.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports: clk, rst (async active-low), push/pushFlit (write), pop (read),
//        front (oldest flit, don't-care when empty), full, empty.
module flit_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] pushFlit,
   input  logic             pop,
   output logic [WIDTH-1:0] front,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;
   logic [PW:0]      count;
   logic             doPush;
   logic             doPop;

   assign full   = (count == (PW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign front  = mem[rdPtr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only observed while count > 0.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushFlit;
   end

endmodule

// File: rtl/input_port_controller.sv
// Router input port: buffers flits, latches the head's route, forwards the packet on grants.
// Latency: push at t -> route latched t+1 -> earliest forward t+2; one flit/cycle steady state.
// Backpressure: in_ready = !full; flits leave only on sa_grant while out_valid (no grant->ready path).
//
// Ports: clk, rst (async active-low); in_flit/in_valid/in_ready (upstream link);
//        HeadFlit -> decoder, RequestMessage <- decoder; sa_request/sa_request_valid/sa_grant
//        (switch allocator); out_flit/out_valid (crossbar); proto_error (stray flit dropped).
module input_port_controller
   import noc_pkg::*;
#(
   parameter int N             = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int PhitPerFlit   = 2,
   parameter int REQUEST_WIDTH = 2,
   parameter int BUFFER_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PhitPerFlit*DATA_WIDTH-1:0] in_flit,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [PhitPerFlit*DATA_WIDTH-1:0] HeadFlit,
   input  logic [REQUEST_WIDTH-1:0]      RequestMessage,
   output logic [REQUEST_WIDTH-1:0]      sa_request,
   output logic                          sa_request_valid,
   input  logic                          sa_grant,
   output logic [PhitPerFlit*DATA_WIDTH-1:0] out_flit,
   output logic                          out_valid,
   output logic                          proto_error
);

   localparam int FW = PhitPerFlit * DATA_WIDTH;

   if (N < 2 || BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : gBadParams
      $error("input_port_controller: N must be >=2 and BUFFER_DEPTH a power of two >=2");
   end

   ipcState_t       state;
   ipcState_t       stateNext;
   logic [FW-1:0]   front;
   logic [TYPE_W-1:0] frontType;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            latchReq;
   logic            dropStray;
   logic            outValid;
   logic            reqValid;

   assign frontType = front[FW-1 -: TYPE_W];
   assign push      = in_valid && !full;
   assign pop       = (outValid && sa_grant) || dropStray;

   flit_fifo #(
      .WIDTH (FW),
      .DEPTH (BUFFER_DEPTH)
   ) uFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pushFlit (in_flit),
      .pop      (pop),
      .front    (front),
      .full     (full),
      .empty    (empty)
   );

   // Everything here depends on registered state only, except the pop decision,
   // which feeds FIFO state and never loops back to in_ready/out_valid.
   always_comb begin
      stateNext = state;
      latchReq  = 1'b0;
      dropStray = 1'b0;
      outValid  = 1'b0;
      reqValid  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (opensPacket(frontType)) begin
                  latchReq  = 1'b1;
                  stateNext = ACTIVE;
               end else begin
                  // Body/tail without a preceding head: discard to resynchronise.
                  dropStray = 1'b1;
               end
            end
         end
         ACTIVE: begin
            reqValid = 1'b1;
            outValid = !empty;
            // A head arriving mid-packet is forwarded untouched; only tail/single ends it.
            if (outValid && sa_grant && closesPacket(frontType)) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sa_request <= '0;
      end else begin
         state <= stateNext;
         if (latchReq) sa_request <= RequestMessage;
      end
   end

   assign in_ready         = !full;
   assign HeadFlit         = front;
   assign out_flit         = front;
   assign out_valid        = outValid;
   assign sa_request_valid = reqValid;
   assign proto_error      = dropStray;

endmodule

// File: tb/tb_input_port_controller.sv
// Self-checking bench for input_port_controller: directed packet scenarios plus random traffic.
// Latency: n/a (testbench).
// Backpressure: random in_valid / sa_grant exercise full and stalled conditions.
module tb_input_port_controller;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int PPF   = 2;
   localparam int RW    = 2;
   localparam int DEPTH = 4;
   localparam int FW    = DW * PPF;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] inFlit;
   logic          inValid;
   logic          inReady;
   logic [FW-1:0] headFlit;
   logic [RW-1:0] requestMessage;
   logic [RW-1:0] saRequest;
   logic          saRequestValid;
   logic          saGrant;
   logic [FW-1:0] outFlit;
   logic          outValid;
   logic          protoError;

   int checks = 0;
   int errors = 0;

   // Behavioural model: buffer contents, whether a packet route is held, the held route.
   logic [FW-1:0] mq[$];
   bit            mInPacket;
   logic [RW-1:0] mRoute;

   always #5 clk = ~clk;

   // Stand-in decoder: destination is the low RW bits of the flit.
   assign requestMessage = headFlit[RW-1:0];

   input_port_controller #(
      .N(N), .DATA_WIDTH(DW), .PhitPerFlit(PPF), .REQUEST_WIDTH(RW), .BUFFER_DEPTH(DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_flit          (inFlit),
      .in_valid         (inValid),
      .in_ready         (inReady),
      .HeadFlit         (headFlit),
      .RequestMessage   (requestMessage),
      .sa_request       (saRequest),
      .sa_request_valid (saRequestValid),
      .sa_grant         (saGrant),
      .out_flit         (outFlit),
      .out_valid        (outValid),
      .proto_error      (protoError)
   );

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] dest,
                                        input logic [11:0] payload);
      return {t, payload, dest};
   endfunction

   function automatic bit isStart(input logic [FW-1:0] f);
      return f[FW-1:FW-2] == 2'b01 || f[FW-1:FW-2] == 2'b11;
   endfunction

   function automatic bit isEnd(input logic [FW-1:0] f);
      return f[FW-1:FW-2] == 2'b10 || f[FW-1:FW-2] == 2'b11;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compareModel();
      bit nonEmpty;
      nonEmpty = mq.size() > 0;
      chk("in_ready", 32'(inReady), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(outValid), 32'(mInPacket && nonEmpty));
      chk("sa_request_valid", 32'(saRequestValid), 32'(mInPacket));
      chk("sa_request", 32'(saRequest), 32'(mRoute));
      chk("proto_error", 32'(protoError), 32'(!mInPacket && nonEmpty && !isStart(mq[0])));
      if (nonEmpty) begin
         chk("out_flit", 32'(outFlit), 32'(mq[0]));
         chk("HeadFlit", 32'(headFlit), 32'(mq[0]));
      end
   endtask

   // Advance the model by one clock edge using the inputs presented in this cycle.
   task automatic modelEdge(input bit v, input logic [FW-1:0] f, input bit g);
      bit accept;
      accept = v && (mq.size() < DEPTH);
      if (mq.size() > 0) begin
         if (mInPacket) begin
            if (g) begin
               if (isEnd(mq[0])) mInPacket = 0;
               void'(mq.pop_front());
            end
         end else if (isStart(mq[0])) begin
            mInPacket = 1;
            mRoute    = mq[0][RW-1:0];
         end else begin
            void'(mq.pop_front());
         end
      end
      if (accept) mq.push_back(f);
   endtask

   task automatic modelReset();
      mq.delete();
      mInPacket = 0;
      mRoute    = '0;
   endtask

   // One cycle: drive at the falling edge, compare, step model at the rising edge.
   // Returns 1 ns after the rising edge so callers can pin literal expectations.
   task automatic step(input bit v, input logic [FW-1:0] f, input bit g);
      @(negedge clk);
      inValid = v;
      inFlit  = f;
      saGrant = g;
      #1;
      compareModel();
      @(posedge clk);
      modelEdge(v, f, g);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b0;
      #1;
      modelReset();
      chk("rst in_ready", 32'(inReady), 32'd1);
      chk("rst out_valid", 32'(outValid), 32'd0);
      chk("rst sa_request_valid", 32'(saRequestValid), 32'd0);
      chk("rst proto_error", 32'(protoError), 32'd0);
      #2;
      rst = 1'b1;
   endtask

   initial begin
      int pktLeft;
      logic [1:0] pktDest;
      logic [FW-1:0] f;
      logic [1:0] t;

      rst     = 1'b0;
      inValid = 1'b0;
      inFlit  = '0;
      saGrant = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      chk("reset sa_request", 32'(saRequest), 32'd0);
      #1;
      rst = 1'b1;
      step(0, '0, 0);
      chk("idle in_ready", 32'(inReady), 32'd1);
      chk("idle out_valid", 32'(outValid), 32'd0);

      // Head/body/tail with route 2, grant held high.
      step(1, mk(2'b01, 2'd2, 12'h111), 1);
      chk("hbt req not yet valid", 32'(saRequestValid), 32'd0);
      step(1, mk(2'b00, 2'd2, 12'h222), 1);
      chk("hbt req valid", 32'(saRequestValid), 32'd1);
      chk("hbt req value", 32'(saRequest), 32'd2);
      chk("hbt first out", 32'(outFlit), 32'(mk(2'b01, 2'd2, 12'h111)));
      step(1, mk(2'b10, 2'd2, 12'h333), 1);
      chk("hbt second out", 32'(outFlit), 32'(mk(2'b00, 2'd2, 12'h222)));
      step(0, '0, 1);
      chk("hbt third out", 32'(outFlit), 32'(mk(2'b10, 2'd2, 12'h333)));
      step(0, '0, 1);
      chk("hbt req dropped", 32'(saRequestValid), 32'd0);

      // Fill with grant low; fifth flit refused; then drain.
      step(1, mk(2'b01, 2'd1, 12'hA01), 0);
      step(1, mk(2'b00, 2'd1, 12'hA02), 0);
      step(1, mk(2'b00, 2'd1, 12'hA03), 0);
      step(1, mk(2'b10, 2'd1, 12'hA04), 0);
      chk("full in_ready", 32'(inReady), 32'd0);
      step(1, mk(2'b00, 2'd1, 12'hBAD), 0);
      chk("full still", 32'(inReady), 32'd0);
      chk("full front", 32'(outFlit), 32'(mk(2'b01, 2'd1, 12'hA01)));
      repeat (4) step(0, '0, 1);
      chk("drained in_ready", 32'(inReady), 32'd1);
      chk("drained out_valid", 32'(outValid), 32'd0);
      chk("drained req", 32'(saRequestValid), 32'd0);

      // Stray body while idle.
      step(1, mk(2'b00, 2'd3, 12'h555), 0);
      chk("stray pulse", 32'(protoError), 32'd1);
      step(0, '0, 0);
      chk("stray pulse ends", 32'(protoError), 32'd0);
      chk("stray no request", 32'(saRequestValid), 32'd0);

      // Single with route 0, then head with route 3.
      step(1, mk(2'b11, 2'd0, 12'h777), 1);
      step(1, mk(2'b01, 2'd3, 12'h888), 1);
      chk("single req value", 32'(saRequest), 32'd0);
      chk("single req valid", 32'(saRequestValid), 32'd1);
      step(0, '0, 1);
      chk("gap idle", 32'(saRequestValid), 32'd0);
      step(1, mk(2'b10, 2'd3, 12'h999), 1);
      chk("next req value", 32'(saRequest), 32'd3);
      chk("next req valid", 32'(saRequestValid), 32'd1);
      repeat (3) step(0, '0, 1);

      // Reset mid-packet, then leftover body arrives and is dropped.
      step(1, mk(2'b01, 2'd1, 12'hC01), 0);
      step(1, mk(2'b00, 2'd1, 12'hC02), 0);
      doReset();
      step(1, mk(2'b00, 2'd1, 12'hC03), 0);
      chk("post-reset stray", 32'(protoError), 32'd1);
      step(0, '0, 0);

      // Random traffic: mostly well-formed packets with occasional stray types.
      pktLeft = 0;
      pktDest = '0;
      for (int i = 0; i < 3000; i++) begin
         bit v;
         v = ($urandom_range(0, 9) < 7);
         if (pktLeft == 0) begin
            pktDest = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
               t = 2'b11;
            end else begin
               t = 2'b01;
               pktLeft = $urandom_range(1, 4);
            end
         end else begin
            pktLeft--;
            t = (pktLeft == 0) ? 2'b10 : 2'b00;
         end
         if ($urandom_range(0, 19) == 0) t = 2'($urandom_range(0, 3));
         f = mk(t, pktDest, 12'($urandom));
         if (!v) begin
            // Keep generator state unchanged when nothing is offered.
            if (t == 2'b01 || t == 2'b11) pktLeft = 0;
            else pktLeft++;
         end else if (inReady == 1'b0) begin
            // Flit not taken this cycle; it will be re-generated in sequence.
            if (t == 2'b01 || t == 2'b11) pktLeft = 0;
            else pktLeft++;
         end
         step(v, f, ($urandom_range(0, 9) < 6));
         if (i == 1500) doReset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
